// File: rtl/pixel_scanout_if.sv
// Scan-out engine bundle: frame configuration, memory read bus and outbound pixel stream.
// master is the engine's view, slave is the memory/display environment's view.
interface pixel_scanout_if #(
   parameter int ADDR_W = 32
);
   logic              enable_i;
   logic [ADDR_W-1:0] fb_base0_i;
   logic [ADDR_W-1:0] fb_base1_i;
   logic              frame_idx_i;
   logic              mem_req_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_gnt_i;
   logic              mem_rvalid_i;
   logic [31:0]       mem_rdata_i;
   logic              pixel_valid_o;
   logic              pixel_ready_i;
   logic [23:0]       pixel_data_o;
   logic              frame_done_o;
   logic              busy_o;

   modport master (
      input  enable_i, fb_base0_i, fb_base1_i, frame_idx_i,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, pixel_ready_i,
      output mem_req_o, mem_addr_o, pixel_valid_o, pixel_data_o, frame_done_o, busy_o
   );

   modport slave (
      output enable_i, fb_base0_i, fb_base1_i, frame_idx_i,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i, pixel_ready_i,
      input  mem_req_o, mem_addr_o, pixel_valid_o, pixel_data_o, frame_done_o, busy_o
   );
endinterface

// File: rtl/pixel_scanout.sv
// Framebuffer scan-out: reads H_RES*V_RES words per frame, streams pixels through a FWFT FIFO.
// Grant-to-pixel latency is response latency + 1; requests stop when FIFO + in-flight reach FIFO_DEPTH.
module pixel_scanout #(
   parameter int H_RES      = 320,
   parameter int V_RES      = 240,
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 32
) (
   input  logic           clk_i,
   input  logic           rst_i,
   pixel_scanout_if.master bus
);
   localparam int N      = H_RES * V_RES;
   localparam int CNT_W  = $clog2(N + 1);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0]  LAST    = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
   localparam logic [FCNT_W-1:0] F_ONE   = FCNT_W'(1);
   localparam logic [PTR_W-1:0]  P_ONE   = PTR_W'(1);
   localparam logic [FCNT_W:0]   CREDITS = (FCNT_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
   logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
   logic [FCNT_W-1:0] outst_q, outst_d;
   logic [FCNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [23:0]       fifo_mem_q [FIFO_DEPTH];

   logic              gnt, wr_en, rd_en, last_pix, fifo_empty;
   logic [FCNT_W:0]   in_flight;
   logic [ADDR_W-1:0] next_base;
   logic              unused_rdata;

   assign fifo_empty   = (fifo_cnt_q == '0);
   assign in_flight    = {1'b0, fifo_cnt_q} + {1'b0, outst_q};
   assign next_base    = bus.frame_idx_i ? bus.fb_base1_i : bus.fb_base0_i;
   assign unused_rdata = ^bus.mem_rdata_i[31:24];

   // Requests only while FIFO slots not yet spoken for remain, so a grant can never lose its landing slot.
   assign bus.mem_req_o  = (state_q == FETCH) && (in_flight < CREDITS);
   assign bus.mem_addr_o = base_q + (ADDR_W'(req_cnt_q) << 2);
   assign gnt            = bus.mem_req_o & bus.mem_gnt_i;
   assign wr_en          = bus.mem_rvalid_i && (outst_q != '0);

   assign bus.pixel_valid_o = !fifo_empty;
   assign bus.pixel_data_o  = fifo_empty ? 24'h0 : fifo_mem_q[rd_ptr_q];
   assign rd_en             = bus.pixel_valid_o & bus.pixel_ready_i;
   assign last_pix          = rd_en && (pix_cnt_q == LAST);
   assign bus.frame_done_o  = last_pix;
   assign bus.busy_o        = (state_q != IDLE);

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      req_cnt_d  = req_cnt_q;
      pix_cnt_d  = pix_cnt_q;
      outst_d    = outst_q;
      fifo_cnt_d = fifo_cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;

      unique case (state_q)
         IDLE: begin
            if (bus.enable_i) begin
               base_d    = next_base;
               req_cnt_d = '0;
               pix_cnt_d = '0;
               state_d   = FETCH;
            end
         end
         FETCH: begin
            if (gnt) begin
               req_cnt_d = req_cnt_q + CNT_ONE;
               if (req_cnt_q == LAST) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (last_pix) begin
               if (bus.enable_i) begin
                  base_d    = next_base;
                  req_cnt_d = '0;
                  state_d   = FETCH;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (gnt && !wr_en)      outst_d = outst_q + F_ONE;
      else if (!gnt && wr_en) outst_d = outst_q - F_ONE;

      if (wr_en) wr_ptr_d = wr_ptr_q + P_ONE;
      if (rd_en) rd_ptr_d = rd_ptr_q + P_ONE;

      if (wr_en && !rd_en)      fifo_cnt_d = fifo_cnt_q + F_ONE;
      else if (!wr_en && rd_en) fifo_cnt_d = fifo_cnt_q - F_ONE;

      if (rd_en) pix_cnt_d = last_pix ? '0 : pix_cnt_q + CNT_ONE;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         base_q     <= '0;
         req_cnt_q  <= '0;
         pix_cnt_q  <= '0;
         outst_q    <= '0;
         fifo_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         req_cnt_q  <= req_cnt_d;
         pix_cnt_q  <= pix_cnt_d;
         outst_q    <= outst_d;
         fifo_cnt_q <= fifo_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the head is only visible while the FIFO is non-empty.
   always_ff @(posedge clk_i) begin
      if (wr_en) fifo_mem_q[wr_ptr_q] <= bus.mem_rdata_i[23:0];
   end
endmodule

// File: tb/tb_pixel_scanout.sv
// Bench for pixel_scanout: small 4x2 frame, latency/stall memory model and pixel scoreboard.
module tb_pixel_scanout;
   localparam int H  = 4;
   localparam int V  = 2;
   localparam int D  = 4;
   localparam int AW = 32;
   localparam int N  = H * V;

   logic clk;
   logic rst;

   pixel_scanout_if #(.ADDR_W(AW)) bus ();

   pixel_scanout #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(D), .ADDR_W(AW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        idx;
      logic [31:0] b0;
      logic [31:0] b1;
      int          lat;
      int          gnt_pct;
      int          rdy_pct;
      int          frames;
      int          drop_after;
      int          toggle_cyc;
      int          stall_cyc;
      logic [31:0] exp_first;
      logic [31:0] exp_last;
   } rec_t;

   rec_t tbl [6];

   int tests = 0, fails = 0, cyc = 0, outst = 0, grants = 0, hs_cnt = 0;
   int frames_seen = 0, dut_done = 0, frame_pix = 0, gap = 0, started = 0;
   logic [31:0] first_addr, last_addr, prev_addr;
   logic [23:0] prev_data;
   logic        prev_req_wait, prev_val_wait;
   logic [23:0] pend_dat_q [$];
   int          pend_due_q [$];
   logic [31:0] exp_addr_q [$];
   logic [23:0] exp_pix_q  [$];
   logic        exp_done_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push_frame(input logic [31:0] base);
      logic [31:0] a;
      for (int i = 0; i < N; i++) begin
         a = base + 32'(4 * i);
         exp_addr_q.push_back(a);
         exp_pix_q.push_back(a[25:2]);
         exp_done_q.push_back(i == N - 1);
      end
   endtask

   // One clock: drive inputs at the falling edge, then judge what the next rising edge will do.
   task automatic cycle(input logic en, input int gp, input int rp, input int lat);
      logic done_e;
      @(negedge clk);
      bus.enable_i     = en;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = 32'hDEAD_BEEF;
      if (pend_due_q.size() != 0 && pend_due_q[0] <= cyc) begin
         bus.mem_rvalid_i = 1'b1;
         bus.mem_rdata_i  = {8'hA5, pend_dat_q.pop_front()};
         void'(pend_due_q.pop_front());
         outst--;
      end
      bus.mem_gnt_i     = (int'($urandom_range(99)) < gp);
      bus.pixel_ready_i = (int'($urandom_range(99)) < rp);
      #1;
      if (prev_req_wait) begin
         check("req_hold", 32'(bus.mem_req_o), 32'd1);
         check("addr_hold", bus.mem_addr_o, prev_addr);
      end
      if (bus.mem_req_o && bus.mem_gnt_i) begin
         grants++;
         outst++;
         tests++;
         if (outst > D) begin
            fails++;
            $display("FAIL outstanding: got %0d, limit %0d", outst, D);
         end
         if (grants == 1) first_addr = bus.mem_addr_o;
         if (grants == N) last_addr = bus.mem_addr_o;
         if (exp_addr_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_grant: got addr %h, none expected", bus.mem_addr_o);
         end else begin
            check("mem_addr", bus.mem_addr_o, exp_addr_q.pop_front());
         end
         pend_dat_q.push_back(bus.mem_addr_o[25:2]);
         pend_due_q.push_back(cyc + lat);
      end
      prev_req_wait = bus.mem_req_o & ~bus.mem_gnt_i;
      prev_addr     = bus.mem_addr_o;

      if (prev_val_wait) begin
         check("valid_hold", 32'(bus.pixel_valid_o), 32'd1);
         check("data_hold", {8'h0, bus.pixel_data_o}, {8'h0, prev_data});
      end
      if (bus.pixel_valid_o && bus.pixel_ready_i) begin
         hs_cnt++;
         if (exp_pix_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pixel: got %h, none expected", bus.pixel_data_o);
         end else begin
            done_e = exp_done_q.pop_front();
            check("pixel", {8'h0, bus.pixel_data_o}, {8'h0, exp_pix_q.pop_front()});
            check("frame_done", 32'(bus.frame_done_o), 32'(done_e));
            frame_pix = done_e ? 0 : frame_pix + 1;
            if (done_e) frames_seen++;
         end
      end else begin
         check("done_idle", 32'(bus.frame_done_o), 32'd0);
      end
      if (bus.frame_done_o) dut_done++;
      prev_val_wait = bus.pixel_valid_o & ~bus.pixel_ready_i;
      prev_data     = bus.pixel_data_o;
      cyc++;
   endtask

   task automatic run_test(input int k, input int stop_pix);
      rec_t r;
      logic en, done_ok;
      int   rp, c;
      r = tbl[k];
      grants = 0; hs_cnt = 0; frames_seen = 0; dut_done = 0; frame_pix = 0;
      gap = 0; started = 0; prev_req_wait = 1'b0; prev_val_wait = 1'b0;
      first_addr = '0; last_addr = '0;
      bus.frame_idx_i = r.idx;
      bus.fb_base0_i  = r.b0;
      bus.fb_base1_i  = r.b1;
      for (int f = 0; f < r.frames; f++)
         push_frame(((f > 0 && r.toggle_cyc > 0) ? ~r.idx : r.idx) ? r.b1 : r.b0);
      done_ok = 1'b0;
      c = 0;
      while (!done_ok && c < 2000) begin
         if (r.toggle_cyc > 0 && c == r.toggle_cyc) bus.frame_idx_i = ~r.idx;
         if (r.stall_cyc > 0 && c == r.stall_cyc) begin
            check("stall_grants", grants, D);
            check("stall_req_low", 32'(bus.mem_req_o), 32'd0);
         end
         en = (c == 0) || (frames_seen < r.frames - 1) ||
              (frames_seen == r.frames - 1 && frame_pix < r.drop_after);
         rp = (c < r.stall_cyc) ? 0 : r.rdy_pct;
         cycle(en, r.gnt_pct, rp, r.lat);
         if (bus.busy_o) started = 1;
         else if (started != 0 && frames_seen < r.frames) gap++;
         if (stop_pix > 0 && hs_cnt >= stop_pix) done_ok = 1'b1;
         if (frames_seen == r.frames && !bus.busy_o) done_ok = 1'b1;
         c++;
      end
      if (!done_ok) begin
         tests++;
         fails++;
         $display("FAIL timeout test %0d: frames %0d of %0d, pixels %0d", k, frames_seen, r.frames, hs_cnt);
      end
      if (stop_pix == 0) begin
         check("frames_done", dut_done, r.frames);
         check("pixel_count", hs_cnt, r.frames * N);
         check("grant_count", grants, r.frames * N);
         check("busy_gap", gap, 0);
         check("first_addr", first_addr, r.exp_first);
         check("last_addr", last_addr, r.exp_last);
         repeat (3) cycle(1'b0, 100, 100, r.lat);
         check("busy_end", 32'(bus.busy_o), 32'd0);
         check("req_end", 32'(bus.mem_req_o), 32'd0);
         check("exp_left", exp_pix_q.size(), 0);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.enable_i = 1'b0; bus.fb_base0_i = '0; bus.fb_base1_i = '0; bus.frame_idx_i = 1'b0;
      bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0; bus.pixel_ready_i = 1'b0;
      //           idx  base0          base1          lat gnt rdy frm drop tog stall first          last
      tbl[0] = '{1'b0, 32'h0000_1000, 32'h0000_2000, 1, 100, 100, 1, 0, 0, 0,  32'h0000_1000, 32'h0000_101C};
      tbl[1] = '{1'b1, 32'h0000_1000, 32'h0000_2000, 1, 100, 100, 2, 0, 3, 0,  32'h0000_2000, 32'h0000_201C};
      tbl[2] = '{1'b0, 32'h0000_1000, 32'h0000_2000, 1, 100, 100, 1, 0, 0, 20, 32'h0000_1000, 32'h0000_101C};
      tbl[3] = '{1'b0, 32'h0000_1000, 32'h0000_2000, 5, 60,  100, 1, 0, 0, 0,  32'h0000_1000, 32'h0000_101C};
      tbl[4] = '{1'b0, 32'h0000_1000, 32'h0000_2000, 1, 100, 100, 4, 3, 0, 0,  32'h0000_1000, 32'h0000_101C};
      tbl[5] = '{1'b1, 32'h0000_1000, 32'hFFFF_FFF0, 3, 70,  50,  2, 0, 0, 0,  32'hFFFF_FFF0, 32'h0000_000C};

      repeat (3) @(negedge clk);
      #1;
      check("rst_req", 32'(bus.mem_req_o), 32'd0);
      check("rst_addr", bus.mem_addr_o, 32'd0);
      check("rst_valid", 32'(bus.pixel_valid_o), 32'd0);
      check("rst_data", {8'h0, bus.pixel_data_o}, 32'd0);
      check("rst_done", 32'(bus.frame_done_o), 32'd0);
      check("rst_busy", 32'(bus.busy_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int k = 0; k < 6; k++) run_test(k, 0);

      // Abort a frame after 5 pixels with an asynchronous reset, then restart from base+0.
      run_test(0, 5);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_req", 32'(bus.mem_req_o), 32'd0);
      check("arst_addr", bus.mem_addr_o, 32'd0);
      check("arst_valid", 32'(bus.pixel_valid_o), 32'd0);
      check("arst_data", {8'h0, bus.pixel_data_o}, 32'd0);
      check("arst_done", 32'(bus.frame_done_o), 32'd0);
      check("arst_busy", 32'(bus.busy_o), 32'd0);
      pend_dat_q.delete(); pend_due_q.delete();
      exp_addr_q.delete(); exp_pix_q.delete(); exp_done_q.delete();
      outst = 0;
      bus.mem_rvalid_i = 1'b0;
      bus.enable_i     = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      run_test(0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pixel_scanout.md
Name: pixel_scanout

Overview:
- Framebuffer scan-out engine. Fetches one frame of 24-bit pixels from memory over a simple request/grant/response bus.
- Emits the pixels in raster order on a valid/ready stream that feeds the display interface.
- Selects between two framebuffers from the display's frame index, latched once per frame. An internal FIFO absorbs memory latency and sink backpressure.

Parameters:
- H_RES, 320, pixels per line
- V_RES, 240, lines per frame
- FIFO_DEPTH, 8, pixel FIFO entries; power of two, 2..64
- ADDR_W, 32, memory byte-address width

Ports:
- clk_i  in  1  clock; all logic on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- enable_i  in  1  start/continue scan-out
- fb_base0_i  in  ADDR_W  byte base of buffer 0; word aligned
- fb_base1_i  in  ADDR_W  byte base of buffer 1; word aligned
- frame_idx_i  in  1  buffer select; 0 selects base0, 1 selects base1
- mem_req_o  out  1  read request
- mem_addr_o  out  ADDR_W  read byte address
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid; responses arrive in order
- mem_rdata_i  in  32  word 0x00RRGGBB
- pixel_valid_o  out  1  pixel available
- pixel_ready_i  in  1  sink accepts pixel
- pixel_data_o  out  24  pixel {R,G,B}
- frame_done_o  out  1  one-cycle pulse on the last pixel handshake of a frame
- busy_o  out  1  high while a frame is in progress

Behaviour:
- Reset values: all outputs 0; FIFO empty; counters 0; FSM in IDLE. Reset asserted mid-frame aborts the frame immediately. The memory side shares the same reset, so no responses are expected after reset.
- Frame size N = H_RES*V_RES. Counter widths are clog2(N+1).
- FSM states:
  - IDLE: when enable_i=1, latch base = frame_idx_i ? fb_base1_i : fb_base0_i, clear counters, go to FETCH. busy_o=1 from the next cycle.
  - FETCH: issue requests until N requests are granted, then go to DRAIN.
  - DRAIN: wait until the last pixel handshakes. Then, if enable_i=1, relatch base and go directly to FETCH (back-to-back frames, no gap cycle); else go to IDLE.
- The frame is atomic. Deasserting enable_i mid-frame has no effect until the frame completes. Base and frame_idx_i changes mid-frame are ignored.
- Request issue:
  - mem_req_o=1 in FETCH when (fifo_count + outstanding) < FIFO_DEPTH.
  - mem_addr_o = base + 4*req_count, modulo 2^ADDR_W (wraps silently).
  - mem_req_o and mem_addr_o hold stable until mem_gnt_i. req_count increments on req&gnt.
- Outstanding counter: +1 on req&gnt, -1 on mem_rvalid_i; both in the same cycle leaves it unchanged. The credit rule guarantees the FIFO never overflows. mem_rvalid_i with zero outstanding is a protocol error and is ignored (no write).
- FIFO write on mem_rvalid_i with data mem_rdata_i[23:0]; bits [31:24] are discarded.
- FIFO read on pixel_valid_o & pixel_ready_i.
  - pixel_valid_o = FIFO non-empty; pixel_data_o = FIFO head (first-word fall-through).
  - Simultaneous write and read on a full or empty FIFO is legal. On empty with write, the pixel is visible the next cycle (min latency: grant to pixel_valid_o = response latency + 1).
- pix_count increments on each output handshake. When the handshake brings pix_count to N: frame_done_o=1 for that cycle, pix_count clears, and busy_o drops the next cycle unless the next frame starts immediately.
- pixel_valid_o, once high, stays high with stable data until accepted.

Test Plan:
- H_RES=4, V_RES=2, FIFO_DEPTH=4, fb_base0_i=0x1000, frame_idx_i=0, memory returns addr>>2 with 1-cycle latency, sink always ready -> addresses 0x1000..0x101C in order, pixels 0x000400..0x000407, frame_done_o exactly once on the 8th pixel.
- Same setup, frame_idx_i=1, fb_base1_i=0x2000, frame_idx_i toggled mid-frame -> all 8 addresses in 0x2000..0x201C; the next frame uses the new index.
- pixel_ready_i=0 for 20 cycles at frame start -> at most 4 grants issued, mem_req_o stays low once credits are exhausted, no data lost; release -> 8 pixels in order.
- Memory latency 5 cycles, random mem_gnt_i stalls -> mem_addr_o is stable while mem_req_o&!mem_gnt_i, pixel order correct, outstanding never exceeds 4.
- enable_i held high over 3 frames -> no idle cycle between frames, 24 pixels, 3 frame_done_o pulses; enable_i dropped after 3 pixels of frame 4 -> frame 4 completes, then busy_o=0.
- rst_i pulsed after 5 pixels -> all outputs 0 asynchronously; after release with enable_i=1, scan restarts at base+0.
